bw_io_ddr_clk_seq_xn: RTL and testbench

//  Parametrised controller for NPAIR DDR differential clock pad pairs (dram_ck_p/n).

---
 rtl/bw_io_ddr_clk_seq_xn.sv | 155 +++++++++++++++
 tb/tb_bw_io_ddr_clk_seq_xn.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_ddr_clk_seq_xn.sv
// Staggered ramp-up/ramp-down of DDR differential clock pad enables, plus the
// per-pair boundary-scan chain. Optional macro: BW_IO_DDR_CLK_STAGGER_EN.
module bw_io_ddr_clk_seq_xn #(
  parameter int NPAIR = 4,
  parameter int STG_W = 4
) (
  input  logic                 rclk,
  input  logic                 rst_l,
  input  logic                 dram_io_clk_enable,
  input  logic [STG_W-1:0]     stagger_cyc,
  input  logic [NPAIR-1:0]     pair_mask,
  input  logic                 hiz_n,
  input  logic                 mode_ctrl,
  input  logic                 clock_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  input  logic                 bsi,
  input  logic [NPAIR-1:0]     ck_pad_p,
  input  logic [NPAIR-1:0]     ck_pad_n,
  output logic [NPAIR-1:0]     ck_en,
  output logic [NPAIR-1:0]     ck_oe,
  output logic [2*NPAIR-1:0]   ck_bs_drv,
  output logic                 seq_busy,
  output logic                 seq_done,
  output logic                 bso
);

  localparam int PTR_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NPAIR - 1);

  typedef enum logic [1:0] {IDLE, UP, ON, DOWN} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [STG_W-1:0]   cnt, cnt_n;
  logic [NPAIR-1:0]   ck_en_n;
  logic               en_q;
  logic [2*NPAIR-1:0] bs_sh, bs_cap;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ck_en_n = ck_en;
    unique case (state)
      IDLE: if (en_q) begin
        state_n = UP;
        ptr_n   = '0;
        cnt_n   = stagger_cyc;
      end
      ON: if (!en_q) begin
        state_n = DOWN;
        ptr_n   = LAST;
        cnt_n   = stagger_cyc;
      end
`ifdef BW_IO_DDR_CLK_STAGGER_EN
      // ptr is the next pair to enable; a reversal starts from the last one enabled.
      UP: begin
        if (!en_q) begin
          if (ptr == '0) state_n = IDLE;
          else begin
            state_n = DOWN;
            ptr_n   = ptr - 1'b1;
            cnt_n   = stagger_cyc;
          end
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          ck_en_n[ptr] = ~pair_mask[ptr];
          cnt_n        = stagger_cyc;
          if (ptr == LAST) state_n = ON;
          else             ptr_n   = ptr + 1'b1;
        end
      end
      // ptr is the next pair to disable; pairs 0..ptr are still on.
      DOWN: begin
        if (en_q) begin
          if (ptr == LAST) state_n = ON;
          else begin
            state_n = UP;
            ptr_n   = ptr + 1'b1;
            cnt_n   = stagger_cyc;
          end
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          ck_en_n[ptr] = 1'b0;
          cnt_n        = stagger_cyc;
          if (ptr == '0) state_n = IDLE;
          else           ptr_n   = ptr - 1'b1;
        end
      end
`else
      // Unstaggered: the whole ramp happens in a single slot.
      UP: begin
        state_n = en_q ? ON : IDLE;
        if (en_q) ck_en_n = ~pair_mask;
      end
      DOWN: begin
        state_n = en_q ? ON : IDLE;
        if (!en_q) ck_en_n = '0;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      en_q     <= 1'b0;
      ck_en    <= '0;
      ck_oe    <= '0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      en_q     <= dram_io_clk_enable;
      ck_en    <= ck_en_n;
      ck_oe    <= {NPAIR{hiz_n}} & ({NPAIR{mode_ctrl}} | ck_en_n);
      seq_busy <= (state_n == UP) || (state_n == DOWN);
      seq_done <= (state_n == ON);
    end
  end

  // Chain bit 2i is p[i], bit 2i+1 is n[i]; bsi enters at bit 0.
  always_comb begin
    bs_cap = '0;
    for (int i = 0; i < NPAIR; i++) begin
      bs_cap[2*i]   = ck_pad_p[i];
      bs_cap[2*i+1] = ck_pad_n[i];
    end
  end

  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      bs_sh     <= '0;
      ck_bs_drv <= '0;
    end else if (update_dr) begin
      ck_bs_drv <= bs_sh;
    end else if (clock_dr) begin
      if (shift_dr) bs_sh <= {bs_sh[2*NPAIR-2:0], bsi};
      else          bs_sh <= bs_cap;
    end
  end

  assign bso = bs_sh[2*NPAIR-1];

endmodule

// File: tb/tb_bw_io_ddr_clk_seq_xn.sv
// Self-checking bench for bw_io_ddr_clk_seq_xn: directed ramp table, corner
// sequences, and randomized traffic against a slot-level reference model.
module tb_bw_io_ddr_clk_seq_xn;

  localparam int NP = 4;
`ifdef BW_IO_DDR_CLK_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  logic          rclk = 1'b0;
  logic          rst_l = 1'b0;
  logic          dram_io_clk_enable = 1'b0;
  logic [3:0]    stagger_cyc = '0;
  logic [NP-1:0] pair_mask = '0;
  logic          hiz_n = 1'b1;
  logic          mode_ctrl = 1'b0;
  logic          clock_dr = 1'b0;
  logic          shift_dr = 1'b0;
  logic          update_dr = 1'b0;
  logic          bsi = 1'b0;
  logic [NP-1:0] ck_pad_p = '0;
  logic [NP-1:0] ck_pad_n = '0;
  logic [NP-1:0] ck_en, ck_oe;
  logic [2*NP-1:0] ck_bs_drv;
  logic          seq_busy, seq_done, bso;

  int errors = 0;
  int checks = 0;

  always #5 rclk = ~rclk;

  bw_io_ddr_clk_seq_xn #(.NPAIR(NP), .STG_W(4)) dut (
    .rclk(rclk), .rst_l(rst_l), .dram_io_clk_enable(dram_io_clk_enable),
    .stagger_cyc(stagger_cyc), .pair_mask(pair_mask), .hiz_n(hiz_n),
    .mode_ctrl(mode_ctrl), .clock_dr(clock_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .bsi(bsi), .ck_pad_p(ck_pad_p), .ck_pad_n(ck_pad_n),
    .ck_en(ck_en), .ck_oe(ck_oe), .ck_bs_drv(ck_bs_drv), .seq_busy(seq_busy),
    .seq_done(seq_done), .bso(bso)
  );

  // Reference model: m_lvl = pairs whose slot has been processed upward,
  // m_dir = ramp direction (0 idle/on), m_t = idle cycles left in the slot.
  int            m_lvl, m_dir, m_t;
  bit            m_enq;
  logic [NP-1:0] m_en, m_oe;
  logic [2*NP-1:0] m_sh, m_upd;
  bit            m_busy, m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NP-1:0] en_nx;
    int s;
    if (!rst_l) begin
      m_lvl = 0; m_dir = 0; m_t = 0; m_enq = 0;
      m_en = '0; m_oe = '0; m_sh = '0; m_upd = '0; m_busy = 0; m_done = 0;
      return;
    end
    s = int'(stagger_cyc);
    en_nx = m_en;
    if (m_dir == 0) begin
      if (m_enq && m_lvl == 0) begin m_dir = 1; m_t = s; end
      else if (!m_enq && m_lvl == NP) begin m_dir = -1; m_t = s; end
    end else if (!STAG) begin
      if (m_dir == 1 && m_enq) begin en_nx = ~pair_mask; m_lvl = NP; end
      if (m_dir == -1 && !m_enq) begin en_nx = '0; m_lvl = 0; end
      m_dir = 0;
    end else if (m_dir == 1) begin
      if (!m_enq) begin
        if (m_lvl == 0) m_dir = 0;
        else begin m_dir = -1; m_t = s; end
      end else if (m_t > 0) m_t--;
      else begin
        en_nx[m_lvl] = ~pair_mask[m_lvl];
        m_lvl++; m_t = s;
        if (m_lvl == NP) m_dir = 0;
      end
    end else begin
      if (m_enq) begin
        if (m_lvl == NP) m_dir = 0;
        else begin m_dir = 1; m_t = s; end
      end else if (m_t > 0) m_t--;
      else begin
        en_nx[m_lvl-1] = 1'b0;
        m_lvl--; m_t = s;
        if (m_lvl == 0) m_dir = 0;
      end
    end
    for (int i = 0; i < NP; i++) m_oe[i] = hiz_n & (mode_ctrl | en_nx[i]);
    if (update_dr) m_upd = m_sh;
    else if (clock_dr) begin
      if (shift_dr) m_sh = {m_sh[2*NP-2:0], bsi};
      else for (int i = 0; i < NP; i++) begin
        m_sh[2*i] = ck_pad_p[i];
        m_sh[2*i+1] = ck_pad_n[i];
      end
    end
    m_en = en_nx;
    m_busy = (m_dir != 0);
    m_done = (m_dir == 0 && m_lvl == NP);
    m_enq = dram_io_clk_enable;
  endtask

  task automatic compare_all();
    check("ck_en", 32'(ck_en), 32'(m_en));
    check("ck_oe", 32'(ck_oe), 32'(m_oe));
    check("ck_bs_drv", 32'(ck_bs_drv), 32'(m_upd));
    check("seq_busy", 32'(seq_busy), 32'(m_busy));
    check("seq_done", 32'(seq_done), 32'(m_done));
    check("bso", 32'(bso), 32'(m_sh[2*NP-1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge rclk);
    @(negedge rclk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_l = 1'b0; dram_io_clk_enable = 1'b0;
    tick(); tick();
    rst_l = 1'b1;
  endtask

  // Ramp table: tick 1 registers the enable (edge k), so edge k+j is tick j+1.
  typedef struct {
    int            s;
    logic [NP-1:0] mask;
    int            done_tick;
    logic [NP-1:0] exp_en;
    int            rise[NP];
  } vec_t;

  vec_t tbl[4];

  initial begin
    int rise[NP], fall[NP], done_t, n;
    logic [NP-1:0] prev;

`ifdef BW_IO_DDR_CLK_STAGGER_EN
    tbl[0] = '{2, 4'h0, 14, 4'hF, '{5, 8, 11, 14}};
    tbl[1] = '{0, 4'h4, 6,  4'hB, '{3, 4, -1, 6}};
    tbl[2] = '{3, 4'h1, 18, 4'hE, '{-1, 10, 14, 18}};
    tbl[3] = '{1, 4'hF, 10, 4'h0, '{-1, -1, -1, -1}};
`else
    tbl[0] = '{7, 4'h0, 3, 4'hF, '{3, 3, 3, 3}};
    tbl[1] = '{0, 4'h4, 3, 4'hB, '{3, 3, -1, 3}};
    tbl[2] = '{3, 4'h1, 3, 4'hE, '{-1, 3, 3, 3}};
    tbl[3] = '{1, 4'hF, 3, 4'h0, '{-1, -1, -1, -1}};
`endif

    do_reset();
    check("reset_ck_en", 32'(ck_en), 32'h0);
    check("reset_busy_done", {30'b0, seq_busy, seq_done}, 32'h0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      stagger_cyc = 4'(tbl[v].s);
      pair_mask = tbl[v].mask;
      dram_io_clk_enable = 1'b1;
      for (int i = 0; i < NP; i++) rise[i] = -1;
      done_t = -1;
      prev = ck_en;
      for (int t = 1; t <= 40 && done_t < 0; t++) begin
        tick();
        for (int i = 0; i < NP; i++) if (!prev[i] && ck_en[i] && rise[i] < 0) rise[i] = t;
        if (seq_done) done_t = t;
        prev = ck_en;
      end
      check($sformatf("tbl%0d_done_tick", v), 32'(done_t), 32'(tbl[v].done_tick));
      check($sformatf("tbl%0d_final_en", v), 32'(ck_en), 32'(tbl[v].exp_en));
      for (int i = 0; i < NP; i++)
        check($sformatf("tbl%0d_rise%0d", v, i), 32'(rise[i]), 32'(tbl[v].rise[i]));
    end

    // Ramp down from ON with S=2.
    do_reset();
    stagger_cyc = 4'd2; pair_mask = '0; dram_io_clk_enable = 1'b1;
    for (int t = 0; t < 40 && !seq_done; t++) tick();
    check("down_start_on", 32'(seq_done), 32'h1);
    dram_io_clk_enable = 1'b0;
    for (int i = 0; i < NP; i++) fall[i] = -1;
    done_t = -1;
    prev = ck_en;
    for (int t = 1; t <= 40 && done_t < 0; t++) begin
      tick();
      for (int i = 0; i < NP; i++) if (prev[i] && !ck_en[i]) fall[i] = t;
      if (!seq_busy && !seq_done) done_t = t;
      prev = ck_en;
    end
    for (int i = 0; i < NP; i++)
      check($sformatf("down_fall%0d", i), 32'(fall[i]), STAG ? 32'(5 + 3*(NP-1-i)) : 32'd3);
    check("down_idle_tick", 32'(done_t), STAG ? 32'd14 : 32'd3);

    // One-cycle enable pulse: UP sees the drop immediately and returns to IDLE.
    do_reset();
    dram_io_clk_enable = 1'b1;
    tick();
    dram_io_clk_enable = 1'b0;
    tick();
    check("pulse_busy", 32'(seq_busy), 32'h1);
    tick();
    check("pulse_idle", {28'b0, ck_en}, {31'b0, seq_busy});

`ifdef BW_IO_DDR_CLK_STAGGER_EN
    // Reversal after two pairs are on: pair 1 clears before pair 0.
    do_reset();
    stagger_cyc = 4'd2; dram_io_clk_enable = 1'b1;
    n = 0;
    while (ck_en != 4'b0011 && n < 40) begin tick(); n++; end
    check("rev_two_on", 32'(ck_en), 32'h3);
    dram_io_clk_enable = 1'b0;
    fall[0] = -1; fall[1] = -1; prev = ck_en; n = 0;
    while ((seq_busy || ck_en != 0) && n < 40) begin
      tick(); n++;
      for (int i = 0; i < 2; i++) if (prev[i] && !ck_en[i]) fall[i] = n;
      prev = ck_en;
    end
    check("rev_order", 32'(fall[1] > 0 && fall[0] > fall[1]), 32'h1);
    check("rev_idle", {27'b0, seq_busy, ck_en}, 32'h0);
`endif

    // Synchronous reset mid-ramp, then a fresh ramp restarts at pair 0.
    do_reset();
    stagger_cyc = 4'd2; hiz_n = 1'b1; mode_ctrl = 1'b1; dram_io_clk_enable = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    rst_l = 1'b0;
    tick();
    check("rst_mid_ck_en", 32'(ck_en), 32'h0);
    check("rst_mid_ck_oe", 32'(ck_oe), 32'h0);
    check("rst_mid_flags", {30'b0, seq_busy, seq_done}, 32'h0);
    rst_l = 1'b1; mode_ctrl = 1'b0;
    n = 0;
    while (ck_en == 0 && n < 40) begin tick(); n++; end
    check("rst_restart_tick", 32'(n), STAG ? 32'd5 : 32'd3);
    check("rst_restart_en", 32'(ck_en), STAG ? 32'h1 : 32'hF);

    // Boundary scan: shift 10110010 MSB first, then update.
    do_reset();
    begin
      logic [7:0] pat;
      pat = 8'b10110010;
      clock_dr = 1'b1; shift_dr = 1'b1;
      for (int j = 7; j >= 0; j--) begin bsi = pat[j]; tick(); end
      clock_dr = 1'b0; update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      check("bs_update", 32'(ck_bs_drv), 32'hB2);
    end
    ck_pad_p = 4'hF; ck_pad_n = 4'h0;
    clock_dr = 1'b1; shift_dr = 1'b0;
    tick();
    shift_dr = 1'b1; bsi = 1'b0;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("bs_out%0d", j), 32'(bso), 32'(j % 2));
      tick();
    end
    clock_dr = 1'b0; shift_dr = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) dram_io_clk_enable = ~dram_io_clk_enable;
      if ($urandom_range(0, 3) == 0) stagger_cyc = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) pair_mask = 4'($urandom);
      hiz_n = ($urandom_range(0, 9) != 0);
      mode_ctrl = ($urandom_range(0, 4) == 0);
      clock_dr = 1'($urandom); shift_dr = 1'($urandom);
      update_dr = ($urandom_range(0, 5) == 0);
      bsi = 1'($urandom);
      ck_pad_p = 4'($urandom); ck_pad_n = 4'($urandom);
      rst_l = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
